// File: rtl/uart_tx_datapath.sv
// ---------------------------------------------------------------------------
// uart_tx_datapath
//
// Purpose:
//   Transmit datapath of a UART. It loads a parallel word, computes its parity
//   bit, shifts the word out LSB first under control of an external transmit
//   controller, and drives a registered serial line.
//
// Configuration:
//   UART_TX_PAR_TYP_EN - when defined, the PAR_TYP port exists and selects
//                        even (0) or odd (1) parity at load time. When it is
//                        undefined, the port is absent and parity is even.
//
// Ports:
//   clk         in   clock; all state updates on its rising edge
//   rst         in   synchronous active-high reset
//   P_DATA      in   [DATA_WIDTH-1:0] parallel word to transmit
//   Data_Valid  in   P_DATA valid this cycle
//   busy        in   controller busy; blocks loads while high
//   ser_en      in   shift enable from the controller
//   mux_sel     in   [1:0] line source: 00 parity, 01 data, 10 stop, 11 start
//   PAR_TYP     in   parity type, 0 even / 1 odd (UART_TX_PAR_TYP_EN only)
//   ser_done    out  all data bits shifted out (combinational)
//   TX_OUT      out  registered serial line
// ---------------------------------------------------------------------------
module uart_tx_datapath #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  busy,
    input  logic                  ser_en,
    input  logic [1:0]            mux_sel,
`ifdef UART_TX_PAR_TYP_EN
    input  logic                  PAR_TYP,
`endif
    output logic                  ser_done,
    output logic                  TX_OUT
);

    localparam int             CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

    localparam logic [1:0] SEL_PARITY = 2'b00;
    localparam logic [1:0] SEL_DATA   = 2'b01;
    localparam logic [1:0] SEL_STOP   = 2'b10;
    localparam logic [1:0] SEL_START  = 2'b11;

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic                  par_q,   par_d;
    logic                  tx_q,    tx_d;

    logic                  load;
    logic                  shift;
    logic                  par_new;

    always_comb begin
        load  = Data_Valid && !busy;
        // Counting stops at DATA_WIDTH, which also freezes the shift register
        // so extra enable cycles after the last data bit are harmless.
        shift = ser_en && (mux_sel == SEL_DATA) && (cnt_q < CNT_FULL);

`ifdef UART_TX_PAR_TYP_EN
        // Odd parity is the complement of even parity.
        par_new = (^P_DATA) ^ PAR_TYP;
`else
        par_new = ^P_DATA;
`endif

        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;

        // A load discards whatever word was in flight, even mid-word.
        if (load) begin
            shift_d = P_DATA;
            cnt_d   = '0;
            par_d   = par_new;
        end else if (shift) begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
        end

        // The line samples the pre-shift LSB and the pre-load parity, so the
        // bit on TX_OUT always belongs to the word that was current this cycle.
        tx_d = 1'b1;
        case (mux_sel)
            SEL_PARITY: tx_d = par_q;
            SEL_DATA:   tx_d = shift_q[0];
            SEL_STOP:   tx_d = 1'b1;
            SEL_START:  tx_d = 1'b0;
            default:    tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= CNT_FULL;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign ser_done = (cnt_q == CNT_FULL);
    assign TX_OUT   = tx_q;

endmodule

// File: tb/tb_uart_tx_datapath.sv
module tb_uart_tx_datapath;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          busy;
    logic          ser_en;
    logic [1:0]    mux_sel;
    logic          PAR_TYP;
    logic          ser_done;
    logic          TX_OUT;

    int total;
    int bad;

    // Reference model: the loaded word, how many of its bits have gone out,
    // the captured parity, and the expected line value.
    logic [DW-1:0] m_word;
    int            m_sent;
    logic          m_par;
    logic          m_tx;

    uart_tx_datapath #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .busy       (busy),
        .ser_en     (ser_en),
        .mux_sel    (mux_sel),
`ifdef UART_TX_PAR_TYP_EN
        .PAR_TYP    (PAR_TYP),
`endif
        .ser_done   (ser_done),
        .TX_OUT     (TX_OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_parity(input logic [DW-1:0] w, input logic pt);
        logic even;
        even = logic'($countones(w) % 2);
`ifdef UART_TX_PAR_TYP_EN
        return even ^ pt;
`else
        return even;
`endif
    endfunction

    // Drive one cycle of inputs, let one rising edge pass, advance the model,
    // and return 1 time unit after the edge so outputs can be sampled.
    task automatic cyc(input logic r, input logic dv, input logic bz, input logic se,
                       input logic [1:0] sel, input logic [DW-1:0] pd, input logic pt);
        logic [DW-1:0] rest;
        rst        = r;
        Data_Valid = dv;
        busy       = bz;
        ser_en     = se;
        mux_sel    = sel;
        P_DATA     = pd;
        PAR_TYP    = pt;
        @(posedge clk);
        if (r) begin
            m_tx   = 1'b1;
            m_word = '0;
            m_sent = DW;
            m_par  = 1'b0;
        end else begin
            rest = (m_sent >= DW) ? '0 : (m_word >> m_sent);
            case (sel)
                2'b00:   m_tx = m_par;
                2'b01:   m_tx = rest[0];
                2'b10:   m_tx = 1'b1;
                default: m_tx = 1'b0;
            endcase
            if (dv && !bz) begin
                m_word = pd;
                m_sent = 0;
                m_par  = model_parity(pd, pt);
            end else if (se && sel == 2'b01 && m_sent < DW) begin
                m_sent = m_sent + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset;
        cyc(1, 0, 0, 0, 2'b10, '0, 0);
        cyc(1, 0, 0, 0, 2'b10, '0, 0);
        total++;
        if (TX_OUT !== 1'b1) begin
            bad++;
            $display("FAIL reset_tx got=%b exp=1", TX_OUT);
        end
        total++;
        if (ser_done !== 1'b1) begin
            bad++;
            $display("FAIL reset_done got=%b exp=1", ser_done);
        end
        cyc(0, 0, 0, 0, 2'b10, '0, 0);
    endtask

    task automatic test_frame;
        logic exp_seq [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
        cyc(0, 1, 0, 0, 2'b10, 8'hA5, 0);
        total++;
        if (ser_done !== 1'b0) begin
            bad++;
            $display("FAIL frame_load_done got=%b exp=0", ser_done);
        end
        cyc(0, 0, 1, 1, 2'b11, '0, 0);
        total++;
        if (TX_OUT !== exp_seq[0]) begin
            bad++;
            $display("FAIL frame_start got=%b exp=%b", TX_OUT, exp_seq[0]);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 1, 2'b01, '0, 0);
            total++;
            if (TX_OUT !== exp_seq[i+1]) begin
                bad++;
                $display("FAIL frame_bit%0d got=%b exp=%b", i, TX_OUT, exp_seq[i+1]);
            end
            total++;
            if (ser_done !== (i == 7)) begin
                bad++;
                $display("FAIL frame_done%0d got=%b exp=%b", i, ser_done, (i == 7));
            end
        end
        cyc(0, 0, 1, 0, 2'b00, '0, 0);
        total++;
        if (TX_OUT !== exp_seq[9]) begin
            bad++;
            $display("FAIL frame_parity got=%b exp=%b", TX_OUT, exp_seq[9]);
        end
        cyc(0, 0, 0, 0, 2'b10, '0, 0);
        total++;
        if (TX_OUT !== exp_seq[10]) begin
            bad++;
            $display("FAIL frame_stop got=%b exp=%b", TX_OUT, exp_seq[10]);
        end
    endtask

    task automatic test_parity;
`ifdef UART_TX_PAR_TYP_EN
        logic [DW-1:0] words [4] = '{8'hA5, 8'h07, 8'hA5, 8'h07};
        logic          types [4] = '{1, 0, 0, 1};
        logic          exps  [4] = '{1, 1, 0, 0};
`else
        logic [DW-1:0] words [4] = '{8'hA5, 8'h07, 8'hFF, 8'h01};
        logic          types [4] = '{0, 0, 0, 0};
        logic          exps  [4] = '{0, 1, 0, 1};
`endif
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, 2'b10, words[i], types[i]);
            cyc(0, 0, 1, 0, 2'b00, '0, 0);
            total++;
            if (TX_OUT !== exps[i]) begin
                bad++;
                $display("FAIL parity%0d word=%h got=%b exp=%b", i, words[i], TX_OUT, exps[i]);
            end
        end
    endtask

    task automatic test_blocked;
        logic [DW-1:0] w = 8'hA5;
        cyc(0, 1, 0, 0, 2'b10, w, 0);
        cyc(0, 0, 1, 1, 2'b11, '0, 0);
        for (int k = 0; k < 8; k++) begin
            if (k == 3) cyc(0, 1, 1, 1, 2'b01, 8'hFF, 1);
            else        cyc(0, 0, 1, 1, 2'b01, '0, 0);
            total++;
            if (TX_OUT !== w[k]) begin
                bad++;
                $display("FAIL blocked_bit%0d got=%b exp=%b", k, TX_OUT, w[k]);
            end
            total++;
            if (ser_done !== (k == 7)) begin
                bad++;
                $display("FAIL blocked_done%0d got=%b exp=%b", k, ser_done, (k == 7));
            end
        end
        cyc(0, 0, 1, 0, 2'b00, '0, 0);
        total++;
        if (TX_OUT !== 1'b0) begin
            bad++;
            $display("FAIL blocked_parity got=%b exp=0", TX_OUT);
        end
    endtask

    task automatic test_saturation;
        logic [DW-1:0] w = 8'h81;
        logic          eb;
        cyc(0, 1, 0, 0, 2'b10, w, 0);
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 1, 1, 2'b01, '0, 0);
            eb = (k < 8) ? w[k] : 1'b0;
            total++;
            if (TX_OUT !== eb) begin
                bad++;
                $display("FAIL sat_bit%0d got=%b exp=%b", k, TX_OUT, eb);
            end
            total++;
            if (ser_done !== (k >= 7)) begin
                bad++;
                $display("FAIL sat_done%0d got=%b exp=%b", k, ser_done, (k >= 7));
            end
        end
    endtask

    task automatic test_midreset;
        logic [DW-1:0] w = 8'h3C;
        cyc(0, 1, 0, 0, 2'b10, w, 0);
        cyc(0, 0, 1, 1, 2'b11, '0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 0, 1, 1, 2'b01, '0, 0);
        cyc(1, 1, 0, 1, 2'b01, 8'hFF, 0);
        total++;
        if (TX_OUT !== 1'b1) begin
            bad++;
            $display("FAIL midrst_tx got=%b exp=1", TX_OUT);
        end
        total++;
        if (ser_done !== 1'b1) begin
            bad++;
            $display("FAIL midrst_done got=%b exp=1", ser_done);
        end
        cyc(0, 1, 0, 0, 2'b10, w, 0);
        cyc(0, 0, 1, 1, 2'b11, '0, 0);
        total++;
        if (TX_OUT !== 1'b0) begin
            bad++;
            $display("FAIL midrst_start got=%b exp=0", TX_OUT);
        end
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 1, 1, 2'b01, '0, 0);
            total++;
            if (TX_OUT !== w[k]) begin
                bad++;
                $display("FAIL midrst_bit%0d got=%b exp=%b", k, TX_OUT, w[k]);
            end
        end
        cyc(0, 0, 1, 0, 2'b00, '0, 0);
        total++;
        if (TX_OUT !== 1'b0) begin
            bad++;
            $display("FAIL midrst_parity got=%b exp=0", TX_OUT);
        end
        total++;
        if (ser_done !== 1'b1) begin
            bad++;
            $display("FAIL midrst_end_done got=%b exp=1", ser_done);
        end
    endtask

    task automatic test_load_wins;
        cyc(0, 1, 0, 0, 2'b10, 8'h5A, 0);
        cyc(0, 0, 1, 1, 2'b11, '0, 0);
        cyc(0, 0, 1, 1, 2'b01, '0, 0);
        cyc(0, 0, 1, 1, 2'b01, '0, 0);
        // load and shift on the same edge: old bit 2 of 5A goes out, count restarts
        cyc(0, 1, 0, 1, 2'b01, 8'hC3, 0);
        total++;
        if (TX_OUT !== 1'b0) begin
            bad++;
            $display("FAIL loadwin_tx got=%b exp=0", TX_OUT);
        end
        total++;
        if (ser_done !== 1'b0) begin
            bad++;
            $display("FAIL loadwin_done got=%b exp=0", ser_done);
        end
        cyc(0, 0, 1, 1, 2'b01, '0, 0);
        total++;
        if (TX_OUT !== 1'b1) begin
            bad++;
            $display("FAIL loadwin_newbit got=%b exp=1", TX_OUT);
        end
        cyc(0, 0, 1, 0, 2'b01, '0, 0);
        total++;
        if (TX_OUT !== 1'b1) begin
            bad++;
            $display("FAIL hold_noshift got=%b exp=1", TX_OUT);
        end
    endtask

    task automatic test_random;
        logic r, dv, bz, se, pt;
        logic [1:0] sel;
        logic [DW-1:0] pd;
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 39) == 0);
            dv  = ($urandom_range(0, 4) == 0);
            bz  = 1'($urandom_range(0, 1));
            se  = ($urandom_range(0, 3) != 0);
            sel = 2'($urandom_range(0, 3));
            pd  = DW'($urandom);
            pt  = 1'($urandom_range(0, 1));
            cyc(r, dv, bz, se, sel, pd, pt);
            total++;
            if (TX_OUT !== m_tx) begin
                bad++;
                $display("FAIL rand_tx cyc=%0d got=%b exp=%b", i, TX_OUT, m_tx);
            end
            total++;
            if (ser_done !== (m_sent == DW)) begin
                bad++;
                $display("FAIL rand_done cyc=%0d got=%b exp=%b", i, ser_done, (m_sent == DW));
            end
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        m_word     = '0;
        m_sent     = DW;
        m_par      = 1'b0;
        m_tx       = 1'b1;
        rst        = 1'b1;
        Data_Valid = 1'b0;
        busy       = 1'b0;
        ser_en     = 1'b0;
        mux_sel    = 2'b10;
        P_DATA     = '0;
        PAR_TYP    = 1'b0;

        test_reset();
        test_frame();
        test_parity();
        test_blocked();
        test_saturation();
        test_midreset();
        test_load_wins();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_datapath.md
UART_TX_DATAPATH -- requirements
Module: uart_tx_datapath

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of the transmitted data word.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: P_DATA  input  DATA_WIDTH  parallel word to transmit.
REQ-005 Port: Data_Valid  input  1  P_DATA valid this cycle.
REQ-006 Port: busy  input  1  transmit-controller busy flag.
REQ-007 Port: ser_en  input  1  serializer shift enable from the controller.
REQ-008 Port: mux_sel  input  2  line source select: 00 parity, 01 data bit, 10 stop (1), 11 start (0).
REQ-009 Port: PAR_TYP  input  1  parity type, 0 even, 1 odd; present only when UART_TX_PAR_TYP_EN is defined.
REQ-010 Port: ser_done  output  1  all DATA_WIDTH data bits shifted out.
REQ-011 Port: TX_OUT  output  1  registered serial line.

Function
REQ-012 Load: when Data_Valid=1 and busy=0, the block SHALL capture P_DATA into shift_reg, clear bit_cnt to 0, and capture the parity bit, all on that edge.
REQ-013 Data_Valid while busy=1 SHALL be ignored; shift_reg, bit_cnt and parity SHALL be unchanged.
REQ-014 Parity SHALL be computed from P_DATA at load time: even = XOR of all bits, odd = XNOR of all bits.
REQ-015 Shift: on an edge with ser_en=1 and mux_sel=01 and bit_cnt<DATA_WIDTH, shift_reg SHALL shift right by one (LSB first, zero fill) and bit_cnt SHALL increment by 1.
REQ-016 ser_en=1 with mux_sel other than 01 SHALL NOT shift or count (start-bit cycle).
REQ-017 bit_cnt SHALL saturate at DATA_WIDTH; further ser_en cycles SHALL NOT shift or count.
REQ-018 ser_done SHALL be combinational, 1 exactly when bit_cnt == DATA_WIDTH.
REQ-019 bit_cnt SHALL be wide enough to hold DATA_WIDTH (clog2(DATA_WIDTH+1) bits).
REQ-020 TX_OUT SHALL register, every edge, the source chosen by mux_sel: 00 parity, 01 shift_reg[0] (pre-shift value), 10 constant 1, 11 constant 0; latency one cycle from mux_sel.
REQ-021 mux_sel=01 with ser_en=0 SHALL drive shift_reg[0] to TX_OUT without shifting.
REQ-022 Load and shift condition on the same edge: load SHALL win.
REQ-023 Load while bit_cnt mid-word (busy=0 glitch case) SHALL discard the old word entirely.

Reset
REQ-024 rst=1 SHALL on the next edge set TX_OUT=1, shift_reg=0, parity=0, bit_cnt=DATA_WIDTH (ser_done=1, idle); rst SHALL override load and shift.
REQ-025 Reset asserted mid-word SHALL abort the word; the next word SHALL transmit cleanly after rst deasserts.

Configuration
REQ-026 Macro UART_TX_PAR_TYP_EN defined: PAR_TYP port exists and is sampled at load per REQ-014.
REQ-027 Macro undefined: PAR_TYP port absent, parity is always even; all other behaviour identical.

Verification
REQ-028 Reset: rst=1 for 2 cycles, mux_sel=10 -> TX_OUT=1, ser_done=1.
REQ-029 Frame: load 8'hA5 (busy=0), then mux_sel=11 one cycle, 8 cycles mux_sel=01 with ser_en=1, mux_sel=00, mux_sel=10 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0(parity even),1; ser_done rises after 8th shift edge.
REQ-030 Odd parity (macro defined): load 8'hA5 with PAR_TYP=1 -> parity bit on TX_OUT = 1; load 8'h07 with PAR_TYP=0 -> parity 1.
REQ-031 Blocked load: mid-frame after 3 shifts, Data_Valid=1 with P_DATA=8'hFF and busy=1 -> remaining bits still from 8'hA5, bit_cnt continues 3->8.
REQ-032 Saturation: 10 ser_en cycles with mux_sel=01 after load of 8'h81 -> exactly 8 shifts, TX_OUT cycles 9-10 = 0, ser_done stays 1.
REQ-033 Mid-word reset: rst=1 after 4 shifts -> next edge TX_OUT=1, ser_done=1; subsequent load of 8'h3C transmits correctly.
